// File: rtl/seq_decoder_scan.sv
// seq_decoder_scan: registered one-hot decoder with direct-decode and auto-scan modes
module seq_decoder_scan #(
    parameter int SEL_W      = 4,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   dout,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);
    localparam int N  = 2**SEL_W;
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  OFF  = ACTIVE_LOW != 0 ? {N{1'b1}} : {N{1'b0}};
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      dout_q, dout_d;
    logic              wrap_q, wrap_d, in_scan, adv;
    always_comb begin
        state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
        // scan counting only continues while staying in SCAN; entry restarts the dwell
        in_scan = state_d == SCAN && state_q == SCAN && !load;
        adv     = in_scan && cnt_q == LAST;
        idx_d   = (state_d != IDLE && load) ? sel : (adv ? idx_q + 1'b1 : idx_q);
        cnt_d   = (in_scan && !adv) ? cnt_q + 1'b1 : '0;
        wrap_d  = adv && &idx_q;
        dout_d  = state_d == IDLE ? OFF : ((N'(1) << idx_d) ^ OFF);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            dout_q  <= OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            dout_q  <= dout_d;
        end
    end
    assign dout = dout_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_seq_decoder_scan.sv
// tb_seq_decoder_scan: table vectors, corner sequences and randomized model check of two configurations
module tb_seq_decoder_scan;
    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [15:0] dout0;
    logic [3:0]  idx0;
    logic        wrap0;
    logic [3:0]  dout1;
    logic [1:0]  idx1;
    logic        wrap1;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    seq_decoder_scan #(.SEL_W(4), .DWELL(3), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
        .dout(dout0), .idx(idx0), .wrap(wrap0));
    seq_decoder_scan #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel[1:0]),
        .dout(dout1), .idx(idx1), .wrap(wrap1));

    // reference: output count, dwell and polarity per instance
    int mn[2] = '{16, 4};
    int md[2] = '{3, 1};
    bit mal[2] = '{1'b0, 1'b1};
    int m_idx[2], m_age[2];
    bit m_act[2], m_scan[2], m_wrap[2];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_age[k] = 0; m_act[k] = 0; m_scan[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // m_age = cycles the current index has been shown in scan mode
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int s;
            s = int'(sel) % mn[k];
            m_wrap[k] = 0;
            if (!en) m_act[k] = 0;
            else if (!mode) begin
                m_act[k] = 1; m_scan[k] = 0;
                if (load) m_idx[k] = s;
            end else begin
                if (load || !m_act[k] || !m_scan[k]) begin
                    if (load) m_idx[k] = s;
                    m_age[k] = 1;
                end else if (m_age[k] == md[k]) begin
                    m_idx[k] = (m_idx[k] + 1) % mn[k];
                    m_wrap[k] = m_idx[k] == 0;
                    m_age[k] = 1;
                end else m_age[k]++;
                m_act[k] = 1; m_scan[k] = 1;
            end
        end
    endtask

    function automatic logic [15:0] exp_dout(int k);
        logic [15:0] e;
        int mask;
        mask = (1 << mn[k]) - 1;
        e = m_act[k] ? (16'd1 << m_idx[k]) : 16'd0;
        if (mal[k]) e = ~e;
        return e & 16'(mask);
    endfunction

    task automatic check_model();
        chk("model_dout0", dout0, exp_dout(0));
        chk("model_idx0", {12'b0, idx0}, 16'(m_idx[0]));
        chk("model_wrap0", {15'b0, wrap0}, {15'b0, m_wrap[0]});
        chk("model_dout1", {12'b0, dout1}, exp_dout(1));
        chk("model_idx1", {14'b0, idx1}, 16'(m_idx[1]));
        chk("model_wrap1", {15'b0, wrap1}, {15'b0, m_wrap[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic en, mode, load;
        logic [3:0] sel;
        logic [15:0] d;
        logic [3:0] i;
        logic w;
    } vec_t;
    vec_t tbl[25];
    logic [3:0] e6[5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic       w6[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 4'd9,  16'h0200, 4'd9,  1'b0},
            '{1'b1, 1'b0, 1'b0, 4'd3,  16'h0200, 4'd9,  1'b0},
            '{1'b1, 1'b0, 1'b1, 4'd14, 16'h4000, 4'd14, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h4000, 4'd14, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h4000, 4'd14, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h4000, 4'd14, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b1},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b0},
            '{1'b1, 1'b1, 1'b1, 4'd15, 16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b1},
            '{1'b1, 1'b0, 1'b1, 4'd6,  16'h0040, 4'd6,  1'b0},
            '{1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 4'd6,  1'b0},
            '{1'b0, 1'b1, 1'b1, 4'd2,  16'h0000, 4'd6,  1'b0},
            '{1'b1, 1'b0, 1'b0, 4'd0,  16'h0040, 4'd6,  1'b0},
            '{1'b1, 1'b1, 1'b1, 4'd15, 16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h8000, 4'd15, 1'b0},
            '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b1},
            '{1'b1, 1'b1, 1'b1, 4'd0,  16'h0001, 4'd0,  1'b0}
        };
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_dout0", dout0, 16'h0000);
        chk("rst_dout1", {12'b0, dout1}, 16'h000F);
        chk("rst_idx0", {12'b0, idx0}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; load = tbl[i].load; sel = tbl[i].sel;
            step();
            chk($sformatf("tbl%0d_dout", i), dout0, tbl[i].d);
            chk($sformatf("tbl%0d_idx", i), {12'b0, idx0}, {12'b0, tbl[i].i});
            chk($sformatf("tbl%0d_wrap", i), {15'b0, wrap0}, {15'b0, tbl[i].w});
        end
        // asynchronous reset in the middle of a scan, checked before any edge
        en = 1'b1; mode = 1'b1; load = 1'b0; sel = 4'd0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout0", dout0, 16'h0000);
        chk("midrst_idx0", {12'b0, idx0}, 16'h0000);
        chk("midrst_wrap0", {15'b0, wrap0}, 16'h0000);
        chk("midrst_dout1", {12'b0, dout1}, 16'h000F);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        step();
        chk("idle_dout1", {12'b0, dout1}, 16'h000F);
        en = 1'b1; mode = 1'b1; load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("al_scan%0d_dout", i), {12'b0, dout1}, {12'b0, e6[i]});
            chk($sformatf("al_scan%0d_wrap", i), {15'b0, wrap1}, {15'b0, w6[i]});
        end
        repeat (500) begin
            en = $urandom_range(0, 9) != 0;
            mode = $urandom_range(0, 3) != 0;
            load = $urandom_range(0, 6) == 0;
            sel = 4'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
